// File: rtl/uart1_pkg.sv
// Shared definitions for the uart1 transmit FIFO slice.
//   seq_state_e                     - send sequencer states (2-bit encoding)
//   UART1_FIFO_DEPTH_BITS_DEFAULT   - default log2 FIFO depth
package uart1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_e;

  localparam int UART1_FIFO_DEPTH_BITS_DEFAULT = 4;

endpackage

// File: rtl/uart1_fifo_mem.sv
// Byte storage for the uart1 transmit FIFO: 2**DEPTH_BITS x 8-bit register array.
// Ports:
//   clk      - system clock
//   we_i     - write enable (one byte per clk)
//   waddr_i  - write address
//   wdata_i  - write byte
//   raddr_i  - read address (combinational read)
//   rdata_o  - byte at raddr_i
// Storage is deliberately not reset; its contents are don't-care until written.
module uart1_fifo_mem #(
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_BITS-1:0] waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [DEPTH_BITS-1:0] raddr_i,
  output logic [7:0]            rdata_o
);

  logic [7:0] mem_q [2**DEPTH_BITS];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart1tx_fifo.sv
// Byte FIFO and send sequencer feeding uart1tx through its data/send/busy handshake.
// Ports:
//   clk, nreset      - clock; asynchronous active-low reset
//   wr_data, wr      - enqueue byte / strobe (dropped when full)
//   flush            - synchronous FIFO clear (wins over wr)
//   overflow_clear   - clears sticky overflow (a dropped write in the same clk wins)
//   full, empty      - registered occupancy flags
//   level            - bytes currently stored (0..2**DEPTH_BITS)
//   overflow         - sticky: a write hit a full FIFO
//   tx_data, tx_send - byte and 1-clk send pulse to uart1tx
//   tx_busy          - busy from uart1tx
module uart1tx_fifo
  import uart1_pkg::*;
#(
  parameter int DEPTH_BITS = UART1_FIFO_DEPTH_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [7:0]          wr_data,
  input  logic                wr,
  input  logic                flush,
  input  logic                overflow_clear,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_BITS:0] level,
  output logic                overflow,
  output logic [7:0]          tx_data,
  output logic                tx_send,
  input  logic                tx_busy
);

  localparam logic [DEPTH_BITS:0]   LVL_FULL = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   LVL_ZERO = {(DEPTH_BITS+1){1'b0}};
  localparam logic [DEPTH_BITS:0]   LVL_ONE  = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ZERO = {DEPTH_BITS{1'b0}};
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_send_q, tx_send_d;
  seq_state_e            state_q, state_d;
  logic                  push_s, pop_s;
  logic [7:0]            rdata_s;

  uart1_fifo_mem #(.DEPTH_BITS(DEPTH_BITS)) u_mem (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // FIFO bookkeeping: push/pop qualification, pointers, level and flags.
  always_comb begin
    // Full is the registered flag, so a pop in the same clk does not make room.
    push_s     = wr && !full_q && !flush;
    // A flush discards the queue, so nothing is popped from it in that clk.
    pop_s      = (state_q == ST_IDLE) && !empty_q && !tx_busy && !flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      level_d  = LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == LVL_ZERO);
    // Set beats clear when both happen in one clk.
    if (wr && full_q) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Send sequencer: one pop per UART frame, then wait for busy to rise and fall.
  always_comb begin
    state_d   = state_q;
    tx_send_d = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          tx_data_d = rdata_s;
          tx_send_d = 1'b1;
          state_d   = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // uart1tx samples send on the edge leaving this state.
      ST_START: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      level_q    <= LVL_ZERO;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_send_q  <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_send_q  <= tx_send_d;
      state_q    <= state_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;

endmodule

// File: tb/tb_uart1tx_fifo.sv
// Self-checking bench for uart1tx_fifo (DEPTH_BITS=2). A behavioural stand-in for
// uart1tx answers tx_send with a busy window of random length and records the byte.
// The reference model is a byte queue plus a "next pop allowed at cycle" timestamp.
module tb_uart1tx_fifo;

  localparam int DB    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr = 1'b0;
  logic          flush = 1'b0;
  logic          overflow_clear = 1'b0;
  logic          full, empty, overflow, tx_send;
  logic [DB:0]   level;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          busy_m = 1'b0;
  logic          ext_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] exp_rx[$];
  logic       m_ovf = 1'b0;
  logic       m_send = 1'b0;
  logic [7:0] m_last = 8'h00;
  longint     cyc = 0;
  longint     ready_at = 0;
  int         bcnt = 0;
  int         m_len;
  logic       pop_now;
  int         rx_count = 0;

  assign tx_busy = busy_m | ext_busy;

  always #5 clk = ~clk;

  uart1tx_fifo #(.DEPTH_BITS(DB)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .wr_data        (wr_data),
    .wr             (wr),
    .flush          (flush),
    .overflow_clear (overflow_clear),
    .full           (full),
    .empty          (empty),
    .level          (level),
    .overflow       (overflow),
    .tx_data        (tx_data),
    .tx_send        (tx_send),
    .tx_busy        (tx_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model and uart1tx stand-in, evaluated on every active edge.
  initial begin
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) begin
        mq.delete();
        exp_rx.delete();
        m_ovf    = 1'b0;
        m_send   = 1'b0;
        m_last   = 8'h00;
        ready_at = 0;
        bcnt     = 0;
        busy_m  <= 1'b0;
      end else begin
        m_len   = mq.size();
        pop_now = !flush && (m_len > 0) && !tx_busy && (cyc >= ready_at);
        m_send  = pop_now;
        if (pop_now) begin
          m_last = mq.pop_front();
          exp_rx.push_back(m_last);
          ready_at = 64'd1 << 40;
        end
        if (wr && m_len == DEPTH) m_ovf = 1'b1;
        else if (overflow_clear) m_ovf = 1'b0;
        if (flush) mq.delete();
        else if (wr && m_len < DEPTH) mq.push_back(wr_data);
        // uart1tx stand-in: samples send, then stays busy for a random frame length
        if (!busy_m && tx_send) begin
          busy_m <= 1'b1;
          bcnt = $urandom_range(12, 3);
          check_eq("rx_expected", (exp_rx.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_rx.size() > 0) check_eq("rx_byte", {24'd0, tx_data}, {24'd0, exp_rx.pop_front()});
          rx_count++;
        end else if (busy_m) begin
          if (bcnt == 1) begin
            busy_m <= 1'b0;
            ready_at = cyc + 2;
          end
          bcnt--;
        end
        cyc++;
      end
    end
  end

  // Compare every output against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (nreset) begin
        check_eq("level",    32'(level),    32'(mq.size()));
        check_eq("full",     32'(full),     (mq.size() == DEPTH) ? 32'd1 : 32'd0);
        check_eq("empty",    32'(empty),    (mq.size() == 0) ? 32'd1 : 32'd0);
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("tx_send",  32'(tx_send),  32'(m_send));
        check_eq("tx_data",  32'(tx_data),  32'(m_last));
      end
    end
  end

  task automatic wr_byte(input logic [7:0] b);
    wr = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (n < 500 && !(mq.size() == 0 && !tx_busy && !m_send && exp_rx.size() == 0
                        && cyc >= ready_at)) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (n < 500) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (n < 50 && !busy_m) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy_m), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_level"},    32'(level),    32'd0);
    check_eq({tag, "_empty"},    32'(empty),    32'd1);
    check_eq({tag, "_full"},     32'(full),     32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
    check_eq({tag, "_tx_send"},  32'(tx_send),  32'd0);
    check_eq({tag, "_tx_data"},  32'(tx_data),  32'd0);
  endtask

  initial begin
    int rx_before;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nreset = 1'b1;
    @(negedge clk);

    // single byte, latency checked by the per-cycle model
    rx_before = rx_count;
    wr_byte(8'h5A);
    drain("drain_single");
    check_eq("single_rx_count", 32'(rx_count - rx_before), 32'd1);

    // three back-to-back bytes
    wr_byte(8'h01);
    wr_byte(8'h02);
    wr_byte(8'h03);
    drain("drain_three");

    // overflow with the sequencer held off by external busy
    ext_busy = 1'b1;
    for (int i = 0; i < 6; i++) wr_byte(8'h10 + 8'(i));
    check_eq("ovf_full",  32'(full),     32'd1);
    check_eq("ovf_level", 32'(level),    32'd4);
    check_eq("ovf_flag",  32'(overflow), 32'd1);
    ext_busy = 1'b0;
    drain("drain_ovf_held");
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'd0);

    // overflow with the sequencer free: first pop plus four buffered bytes
    rx_before = rx_count;
    for (int i = 0; i < 6; i++) wr_byte(8'h20 + 8'(i));
    drain("drain_ovf_free");
    check_eq("ovf_free_rx_count", 32'(rx_count - rx_before), 32'd5);
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;

    // flush during the first frame
    rx_before = rx_count;
    for (int i = 0; i < 4; i++) wr_byte(8'h30 + 8'(i));
    wait_busy("flush_busy");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_level", 32'(level), 32'd0);
    drain("drain_flush");
    check_eq("flush_rx_count", 32'(rx_count - rx_before), 32'd1);

    // wr and flush in the same clk
    ext_busy = 1'b1;
    wr_byte(8'h41);
    wr_byte(8'h42);
    wr = 1'b1;
    wr_data = 8'h43;
    flush = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    flush = 1'b0;
    check_eq("wr_flush_level", 32'(level), 32'd0);
    ext_busy = 1'b0;
    drain("drain_wr_flush");

    // asynchronous reset mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) wr_byte(8'h50 + 8'(i));
    wait_busy("rst_busy");
    @(negedge clk);
    check_eq("rst_pre_level", 32'(level), 32'd3);
    #2 nreset = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    rx_before = rx_count;
    wr_byte(8'hA5);
    drain("drain_after_rst");
    check_eq("after_rst_rx_count", 32'(rx_count - rx_before), 32'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      wr             = ($urandom_range(2, 0) == 0);
      wr_data        = 8'($urandom);
      flush          = ($urandom_range(59, 0) == 0);
      overflow_clear = ($urandom_range(19, 0) == 0);
      @(negedge clk);
    end
    wr = 1'b0;
    flush = 1'b0;
    overflow_clear = 1'b0;
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
